// File: rtl/bcd_pkg.sv
// Shared BCD constants and converter state encoding, also used by the display path.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int MAX_DEC_4DIGIT = 9999;

  function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational acc*10 + digit step of the BCD-to-binary datapath, with digit>9 flag.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0]       i_acc,
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [WIDTH-1:0]       o_sum,
  output logic                   o_bad
);

  localparam int WW = WIDTH + 4;

  logic [WW-1:0] w_ext;
  logic [WW-1:0] w_wide;
  logic [3:0]    w_unused_hi;

  // x*10 as (x<<3)+(x<<1); four guard bits keep the sum exact before wrapping
  assign w_ext       = {4'b0, i_acc};
  assign w_wide      = (w_ext << 3) + (w_ext << 1) + WW'(i_digit);
  assign o_sum       = w_wide[WIDTH-1:0];
  assign w_unused_hi = w_wide[WW-1:WIDTH];
  assign o_bad       = bcd_digit_bad(i_digit);

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Iterative packed-BCD to binary converter, one digit per clock, valid/ready on both sides.
// Optional nibble range checking is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_WIDTH-1:0]        bin_out,
  output logic                        invalid
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SR_W  = BCD_DIGIT_W * DIGITS;

  state_e                 r_state, w_next;
  logic [SR_W-1:0]        r_shift;
  logic [BIN_WIDTH-1:0]   r_acc;
  logic [BIN_WIDTH-1:0]   r_bin;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [BCD_DIGIT_W-1:0] w_digit;
  logic [BIN_WIDTH-1:0]   w_sum;
  logic                   w_bad;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_state == CONV) && (r_cnt == CNT_W'(DIGITS - 1));
  assign w_release = (r_state == DONE) && out_ready;
  assign w_digit   = r_shift[SR_W-1 -: BCD_DIGIT_W];

  bcd_digit_mac #(
    .WIDTH (BIN_WIDTH)
  ) u_mac (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_sum   (w_sum),
    .o_bad   (w_bad)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = CONV;
      CONV:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign bin_out   = r_bin;

  // Shift register walks MSD first; the word is frozen at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= bcd_in;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == CONV) begin
      r_shift <= r_shift << BCD_DIGIT_W;
      r_acc   <= w_sum;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_err;
  logic r_invalid;
  logic w_err_now;

  assign w_err_now = r_err | w_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_invalid <= 1'b0;
      r_bin     <= '0;
    end else if (w_accept) begin
      r_err     <= 1'b0;
      r_invalid <= 1'b0;
    end else if (r_state == CONV) begin
      r_err <= w_err_now;
      if (w_last) begin
        r_invalid <= w_err_now;
        r_bin     <= w_err_now ? '0 : w_sum;
      end
    end
  end

  assign invalid = r_invalid;
`else
  logic w_unused_bad;
  assign w_unused_bad = w_bad;

  // Out-of-range nibbles fold in at face value; the MAC wraps the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_bin <= '0;
    else if (w_last) r_bin <= w_sum;
  end

  assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Scoreboard bench for bcd_to_bin_converter: directed words, expected results queued at accept.
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 4;
  localparam int BW     = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   bcd_in;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] bin_out;
  logic          invalid;

  typedef struct {
    logic [BW-1:0] bin;
    logic          inv;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   hist[$];
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  logic prev_ov = 1'b0;

  bcd_to_bin_converter #(.DIGITS(DIGITS), .BIN_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: latency on each out_valid rise, result compare on each handshake
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), DIGITS);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bin_out", int'(bin_out), int'(e.bin));
          chk("invalid", int'(invalid), int'(e.inv));
        end
      end
      prev_ov = out_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [15:0] w, input int eb, input logic ei);
    int t = 0;
    exp_t e;
    in_valid = 1'b1;
    bcd_in   = w;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.bin = BW'(eb);
    e.inv = ei;
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    hist.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 16'hFFFF;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  logic [15:0] tbl [18];
  int          h0;
  int          t;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bcd_in    = 16'h0000;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_bin_out",   int'(bin_out), 0);
    chk("rst_invalid",   int'(invalid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset two cycles into a conversion aborts it
    send(16'h1234, 1234, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_bin_out",   int'(bin_out), 0);
    chk("abort_in_ready",  int'(in_ready), 1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0042, 42, 1'b0);
    drain();

    // Basic conversion, busy while converting
    send(16'h1234, 1234, 1'b0);
    for (int i = 0; i < DIGITS; i++) begin
      chk("busy_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    drain();

    // Boundaries back to back
    h0 = hist.size();
    send(16'h0000, 0, 1'b0);
    send(16'h9999, 9999, 1'b0);
    send(16'h0001, 1, 1'b0);
    send(16'h1000, 1000, 1'b0);
    for (int i = 0; i < 3; i++) chk("accept_spacing", hist[h0+i+1] - hist[h0+i], DIGITS + 2);
    drain();

    // Backpressure: result held, in_valid ignored
    out_ready = 1'b0;
    send(16'h0510, 510, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    bcd_in   = 16'h9999;
    for (int i = 0; i < 20; i++) begin
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_bin_out",   int'(bin_out), 510);
      chk("hold_in_ready",  int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready",  int'(in_ready), 1);
    drain();

    // Non-decimal nibble
`ifdef BCD_DIGIT_CHECK_EN
    send(16'h12A4, 0, 1'b1);
`else
    send(16'h12A4, 1304, 1'b0);
`endif
    drain();

    // in_valid held high, bcd_in changing every cycle: only IDLE-edge words convert
    for (int k = 0; k < 18; k++) tbl[k] = 16'h3333;
    tbl[0]  = 16'h0007;
    tbl[6]  = 16'h0250;
    tbl[12] = 16'h8421;
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1;
      bcd_in   = tbl[k];
      if (k % 6 == 0) begin
        exp_t e;
        e.inv = 1'b0;
        e.bin = (k == 0) ? BW'(7) : (k == 6) ? BW'(250) : BW'(8421);
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("no_extra_pulses", acc_q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_converter.md
Name: bcd_to_bin_converter

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the binary-to-decimal display path.
- Accepts a packed 4-digit BCD word, for example from decimal switch or keypad entry, over a valid/ready handshake.
- Produces the 14-bit binary value using an iterative multiply-by-10-and-add datapath, one digit per clock.
- Sits between the decimal entry logic and any consumer of binary switch-equivalent values, such as the existing display path for loop-back checking.

Parameters:
- DIGITS, 4, number of BCD digits converted per word.
- BIN_WIDTH, 14, width of the binary result. With defaults it covers 0..9999 without truncation.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a BCD word on bcd_in.
- in_ready  output  1  converter can accept a word; high only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, most significant digit in the top nibble.
- out_valid  output  1  bin_out and invalid are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  BIN_WIDTH  binary result, held stable while out_valid is high.
- invalid  output  1  a nibble greater than 9 was seen; meaningful only with out_valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, accumulator=0, digit counter=0, shift register=0.
  - bin_out=0, out_valid=0, invalid=0.
  - in_ready=1, because it is decoded from state==IDLE.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture bcd_in into the shift register, clear the accumulator and counter, go to CONV.
  - in_valid=0: stay in IDLE.
- CONV:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= acc*10 + top_nibble; shift register <<= 4; counter++.
  - acc*10 is computed as (acc<<3)+(acc<<1) at width BIN_WIDTH+4, then truncated to BIN_WIDTH (modulo 2^BIN_WIDTH).
  - When the counter reaches DIGITS-1 on the current edge, go to DONE. bin_out is loaded with the final accumulator on that same edge.
- DONE:
  - out_valid=1, in_ready=0. bin_out and invalid are held.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - out_ready low: hold indefinitely (backpressure).
- Latency:
  - out_valid rises exactly DIGITS clocks after the accepting edge.
  - Minimum accept-to-accept spacing is DIGITS+2 clocks.
- in_valid is ignored outside IDLE. No input is lost or overwritten mid-conversion.
- A producer changing bcd_in after acceptance has no effect.
- If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.
- Leading zero digits are legal. 0000 gives 0; 9999 gives 14'd9999.
- Reset asserted mid-CONV or in DONE aborts immediately. The pending result is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - Each captured nibble is checked as it is processed. Any nibble greater than 9 sets a sticky error bit.
  - In DONE: invalid=1 and bin_out=0.
  - The sticky bit clears on acceptance of a new word.
- Undefined:
  - No checking; invalid is tied to 0.
  - Nibbles greater than 9 contribute their raw value (for example A=10), and the result wraps modulo 2^BIN_WIDTH.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (IDLE, CONV, DONE);
  - BCD_DIGIT_W=4;
  - BCD_MAX_DIGIT=9;
  - MAX_DEC_4DIGIT=9999.
  The display-side code reuses the same constants.
- One natural sub-module, bcd_digit_mac: combinational acc*10+digit at parameterised width, plus digit>9 detection. It is instantiated once in the CONV datapath.

Test Plan:
- Reset mid-CONV: feed 16'h1234, assert rst_n=0 two cycles later -> out_valid=0, bin_out=0, in_ready=1 immediately. After release, 16'h0042 -> 42.
- Basic conversion: 16'h1234 with out_ready=1 -> out_valid exactly 4 clocks after acceptance, bin_out=1234, in_ready low throughout.
- Boundaries: 16'h0000 -> 0; 16'h9999 -> 9999; 16'h0001 -> 1; 16'h1000 -> 1000. Back-to-back, each accepted exactly 6 clocks apart.
- Backpressure: 16'h0510 with out_ready=0 for 20 cycles -> out_valid and bin_out=510 held stable, in_valid ignored. Raising out_ready -> IDLE next edge.
- Invalid digit: 16'h12A4 -> with BCD_DIGIT_CHECK_EN, invalid=1 and bin_out=0. Without the macro, bin_out=1*1000+2*100+10*10+4=1304 and invalid=0.
- Protocol: in_valid held high continuously with changing bcd_in -> only the word present at each IDLE-accept edge is converted. No extra out_valid pulses.
